// File: rtl/draw_scheduler.sv
// Round-robin scheduler that multiplexes per-object state codes onto the shared draw-state bus,
// with a valid/ready handshake to the drawer, a sticky start latch and a game-over mode.
module draw_scheduler #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned SW      = 4,
  parameter int unsigned OVER_CH = 0,
  localparam int unsigned CW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go_n,
  input  logic              collision,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*SW-1:0] ch_state,
  output logic [NCH-1:0]    ch_grant,
  output logic              draw_valid,
  input  logic              draw_ready,
  output logic [SW-1:0]     draw_state,
  output logic [CW-1:0]     draw_ch,
  output logic              started,
  output logic              game_over
);

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StIssue,
    StOverArb,
    StOverIssue
  } state_e;

  state_e          state_q, state_d;
  logic            started_q, started_d;
  logic            game_over_q, game_over_d;
  logic            draw_valid_q, draw_valid_d;
  logic [SW-1:0]   draw_state_q, draw_state_d;
  logic [CW-1:0]   draw_ch_q, draw_ch_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            handshake;
  logic            found;
  logic [CW-1:0]   pick;
  logic [SW-1:0]   pick_state;
  logic [CW-1:0]   rr_next;

  assign handshake = draw_valid_q & draw_ready;
  assign rr_next   = (draw_ch_q == CW'(NCH - 1)) ? '0 : draw_ch_q + CW'(1);

  // Two-pass priority scan: channels at or above rr_ptr first, then the wrapped-around rest.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && ch_req[i] && (CW'(i) >= rr_ptr_q)) begin
        found = 1'b1;
        pick  = CW'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && ch_req[i]) begin
        found = 1'b1;
        pick  = CW'(i);
      end
    end
  end

  always_comb begin
    pick_state = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (CW'(i) == pick) begin
        pick_state = ch_state[i*SW +: SW];
      end
    end
  end

  always_comb begin
    ch_grant = '0;
    if (handshake) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_grant[i] = (CW'(i) == draw_ch_q);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    started_d    = started_q;
    // Collision only counts once the game has started; a start-cycle collision is ignored.
    game_over_d  = game_over_q | (collision & started_q);
    draw_valid_d = draw_valid_q;
    draw_state_d = draw_state_q;
    draw_ch_d    = draw_ch_q;
    rr_ptr_d     = rr_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (!go_n) begin
          started_d = 1'b1;
          state_d   = StArb;
        end
      end
      StArb: begin
        if (game_over_d) begin
          state_d = StOverArb;
        end else if (found) begin
          draw_valid_d = 1'b1;
          draw_state_d = pick_state;
          draw_ch_d    = pick;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (handshake) begin
          draw_valid_d = 1'b0;
          rr_ptr_d     = rr_next;
          state_d      = game_over_d ? StOverArb : StArb;
        end
      end
      StOverArb: begin
        if (ch_req[OVER_CH]) begin
          draw_valid_d = 1'b1;
          draw_state_d = ch_state[OVER_CH*SW +: SW];
          draw_ch_d    = CW'(OVER_CH);
          state_d      = StOverIssue;
        end
      end
      StOverIssue: begin
        if (handshake) begin
          draw_valid_d = 1'b0;
          state_d      = StOverArb;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      started_q    <= 1'b0;
      game_over_q  <= 1'b0;
      draw_valid_q <= 1'b0;
      draw_state_q <= '0;
      draw_ch_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      started_q    <= started_d;
      game_over_q  <= game_over_d;
      draw_valid_q <= draw_valid_d;
      draw_state_q <= draw_state_d;
      draw_ch_q    <= draw_ch_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign draw_valid = draw_valid_q;
  assign draw_state = draw_state_q;
  assign draw_ch    = draw_ch_q;
  assign started    = started_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: directed stimulus pushes expected grants,
// a negedge monitor pops and compares whenever a grant pulse appears.
module tb_draw_scheduler;
  localparam int unsigned NCH     = 4;
  localparam int unsigned SW      = 4;
  localparam int unsigned OVER_CH = 0;
  localparam int unsigned CW      = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              go_n;
  logic              collision;
  logic [NCH-1:0]    ch_req;
  logic [NCH*SW-1:0] ch_state;
  logic [NCH-1:0]    ch_grant;
  logic              draw_valid;
  logic              draw_ready;
  logic [SW-1:0]     draw_state;
  logic [CW-1:0]     draw_ch;
  logic              started;
  logic              game_over;

  draw_scheduler #(
    .NCH    (NCH),
    .SW     (SW),
    .OVER_CH(OVER_CH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .go_n      (go_n),
    .collision (collision),
    .ch_req    (ch_req),
    .ch_state  (ch_state),
    .ch_grant  (ch_grant),
    .draw_valid(draw_valid),
    .draw_ready(draw_ready),
    .draw_state(draw_state),
    .draw_ch   (draw_ch),
    .started   (started),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Channel codes: ch0=3, ch1=A, ch2=6, ch3=C
  localparam logic [NCH*SW-1:0] BaseStates = 16'hC6A3;

  int n_cmp  = 0;
  int n_bad  = 0;
  int gcount = 0;
  int cyc    = 0;
  int gcyc[$];
  logic [CW+SW-1:0] expq[$];
  logic [CW+SW-1:0] exp_item;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ch_grant !== '0) begin
      gcount++;
      gcyc.push_back(cyc);
      check("grant_onehot", 32'($onehot(ch_grant)), 1);
      check("grant_with_valid", 32'(draw_valid), 1);
      check("grant_bit_matches_ch", 32'(ch_grant), 32'd1 << draw_ch);
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: got ch %0d state %0h expected no grant at %0t",
                 draw_ch, draw_state, $time);
      end else begin
        exp_item = expq.pop_front();
        check("grant_ch", 32'(draw_ch), 32'(exp_item[CW+SW-1:SW]));
        check("grant_state", 32'(draw_state), 32'(exp_item[SW-1:0]));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int ch, input int st);
    expq.push_back({ch[CW-1:0], st[SW-1:0]});
  endtask

  task automatic wait_gc(input int target);
    for (int k = 0; k < 60 && gcount < target; k++) step();
    check("grants_reached", gcount, target);
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 20 && draw_valid !== 1'b1; k++) step();
    check("valid_seen", 32'(draw_valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn     = 1'b0;
    go_n       = 1'b1;
    collision  = 1'b0;
    ch_req     = '0;
    ch_state   = BaseStates;
    draw_ready = 1'b0;
    step(3);
    check("rst_valid", 32'(draw_valid), 0);
    check("rst_started", 32'(started), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_draw_ch", 32'(draw_ch), 0);
    check("rst_draw_state", 32'(draw_state), 0);
    check("rst_grant", 32'(ch_grant), 0);

    // Idle: requests present but no start key
    resetn     = 1'b1;
    ch_req     = 4'hF;
    draw_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle_no_valid", 32'(draw_valid), 0);
    end
    check("idle_not_started", 32'(started), 0);

    // Start, then full round-robin at max throughput
    push(0, 3); push(1, 10); push(2, 6); push(3, 12); push(0, 3); push(1, 10);
    gcyc.delete();
    go_n = 1'b0;
    step();
    go_n = 1'b1;
    check("start_started", 32'(started), 1);
    check("start_valid_late", 32'(draw_valid), 0);
    step();
    check("first_valid", 32'(draw_valid), 1);
    check("first_ch", 32'(draw_ch), 0);
    wait_gc(6);
    if (gcyc.size() >= 6) check("throughput_span", gcyc[5] - gcyc[0], 10);

    // Sparse requests with rr_ptr at 2
    push(3, 12); push(1, 10); push(3, 12);
    ch_req = 4'b1010;
    wait_gc(9);
    ch_req = '0;

    // Stall: held transaction survives state changes and request drop
    draw_ready = 1'b0;
    push(2, 6);
    ch_req = 4'b0100;
    wait_valid();
    for (int k = 0; k < 7; k++) begin
      ch_state = {4{4'(k + 1)}};
      ch_req   = '0;
      step();
      check("stall_valid", 32'(draw_valid), 1);
      check("stall_ch", 32'(draw_ch), 2);
      check("stall_state", 32'(draw_state), 6);
      check("stall_no_grant", 32'(ch_grant), 0);
    end
    draw_ready = 1'b1;
    ch_state   = BaseStates;
    wait_gc(10);
    check("after_hs_valid", 32'(draw_valid), 0);
    check("after_hs_grant", 32'(ch_grant), 0);

    // Collision during ISSUE of ch2: completes, then only ch0 is served
    draw_ready = 1'b0;
    push(2, 6); push(0, 3); push(0, 3); push(0, 3);
    ch_req = 4'b0100;
    wait_valid();
    ch_req    = 4'hF;
    collision = 1'b1;
    step();
    collision = 1'b0;
    check("coll_game_over", 32'(game_over), 1);
    check("coll_keeps_valid", 32'(draw_valid), 1);
    check("coll_keeps_ch", 32'(draw_ch), 2);
    draw_ready = 1'b1;
    wait_gc(14);
    ch_req = 4'b1110;
    step(10);
    check("over_others_ignored", gcount, 14);
    check("over_idle_valid", 32'(draw_valid), 0);
    check("over_sticky", 32'(game_over), 1);

    // Reset with a pending, unaccepted transaction
    draw_ready = 1'b0;
    ch_req     = 4'hF;
    wait_valid();
    resetn = 1'b0;
    step();
    check("mid_rst_valid", 32'(draw_valid), 0);
    check("mid_rst_ch", 32'(draw_ch), 0);
    check("mid_rst_state", 32'(draw_state), 0);
    check("mid_rst_started", 32'(started), 0);
    check("mid_rst_game_over", 32'(game_over), 0);
    check("mid_rst_grant", 32'(ch_grant), 0);
    draw_ready = 1'b1;
    step();
    check("in_rst_ready_no_grant", 32'(ch_grant), 0);
    resetn = 1'b1;
    step(3);
    check("post_rst_valid", 32'(draw_valid), 0);
    check("post_rst_started", 32'(started), 0);

    // Go and collision together in IDLE: start only
    ch_req = 4'b0010;
    push(1, 10);
    go_n      = 1'b0;
    collision = 1'b1;
    step();
    go_n      = 1'b1;
    collision = 1'b0;
    check("go_coll_started", 32'(started), 1);
    check("go_coll_no_over", 32'(game_over), 0);
    wait_gc(15);
    check("go_coll_still_normal", 32'(game_over), 0);
    check("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
